// File: rtl/instr_fetch_unit_if.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit_if
// Instruction-memory request/response bus between the fetch unit and the
// instruction memory.
//
// Signals:
//   imem_req    fetch request (driven by the fetch unit, registered there)
//   imem_addr   fetch address (always equals the fetch unit's pc)
//   imem_rdata  instruction word, valid while imem_ready=1
//   imem_ready  memory completes the outstanding request this cycle
//
// Modports:
//   master  fetch-unit side
//   slave   memory side
// ---------------------------------------------------------------------------
interface instr_fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ready;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rdata,
        input  imem_ready
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rdata,
        output imem_ready
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit
// Multi-cycle fetch stage. Holds the PC, fetches one instruction at a time
// over a ready-based variable-latency memory handshake, issues it to the
// decoder / sign extension, and computes the next PC from pc_src/imm_ext.
// A fetch that waits too long raises a sticky error and parks the unit in
// ERROR until reset.
//
// Parameters:
//   RESET_PC      PC loaded on reset
//   IMEM_TIMEOUT  max FETCH wait cycles before error (0 = no timeout)
//
// Optional build macro:
//   MISALIGN_TRAP_EN  defined: a misaligned next-PC traps into ERROR.
//                     undefined: the next-PC low two bits are cleared.
//
// Ports:
//   i_clk          rising-edge clock
//   i_rst_n        synchronous active-low reset
//   i_stall        downstream hold while an instruction is issued
//   i_pc_src       1: next pc = pc + imm_ext, 0: next pc = pc + 4
//   i_imm_ext      immediate of the issued instruction (two's complement)
//   imem           instruction-memory bus (master side)
//   o_instr        issued instruction word
//   o_pc           address of o_instr
//   o_pc_plus4     pc + 4 for link-register writes
//   o_instr_valid  o_instr / o_pc valid for execution
//   o_fetch_err    sticky fault flag
// ---------------------------------------------------------------------------
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int unsigned IMEM_TIMEOUT = 255
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_stall,
    input  logic                       i_pc_src,
    input  logic signed [31:0]         i_imm_ext,
    instr_fetch_unit_if.master         imem,
    output logic [31:0]                o_instr,
    output logic [31:0]                o_pc,
    output logic [31:0]                o_pc_plus4,
    output logic                       o_instr_valid,
    output logic                       o_fetch_err
);

    localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;
    localparam bit          TIMEOUT_EN   = (IMEM_TIMEOUT != 0);
    localparam logic [31:0] TIMEOUT_LAST = TIMEOUT_EN ? 32'(IMEM_TIMEOUT - 1) : 32'd0;

    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_FETCH = 2'd1,
        S_ISSUE = 2'd2,
        S_ERROR = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_pc;
    logic [31:0] w_pc_nxt;
    logic [31:0] r_instr;
    logic [31:0] w_instr_nxt;
    logic        r_valid;
    logic        w_valid_nxt;
    logic        r_req;
    logic        w_req_nxt;
    logic        r_err;
    logic        w_err_nxt;
    logic [31:0] r_cnt;
    logic [31:0] w_cnt_nxt;
    logic [31:0] w_target;

    // Modulo-2^32 addition; a negative immediate wraps the PC backwards.
    assign w_target = i_pc_src ? (r_pc + 32'(i_imm_ext)) : (r_pc + 32'd4);

    // ------------------------------------------------------------------
    // Next-state / next-output logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_instr_nxt = r_instr;
        w_valid_nxt = r_valid;
        w_req_nxt   = r_req;
        w_err_nxt   = r_err;
        w_cnt_nxt   = r_cnt;

        case (r_state)
            S_BOOT: begin
                w_req_nxt   = 1'b1;
                w_state_nxt = S_FETCH;
            end

            S_FETCH: begin
                // A response in the last allowed wait cycle still wins
                // over the timeout.
                if (imem.imem_ready) begin
                    w_instr_nxt = imem.imem_rdata;
                    w_valid_nxt = 1'b1;
                    w_req_nxt   = 1'b0;
                    w_cnt_nxt   = 32'd0;
                    w_state_nxt = S_ISSUE;
                end else if (TIMEOUT_EN && (r_cnt == TIMEOUT_LAST)) begin
                    w_err_nxt   = 1'b1;
                    w_req_nxt   = 1'b0;
                    w_cnt_nxt   = 32'd0;
                    w_state_nxt = S_ERROR;
                end else begin
                    w_cnt_nxt   = r_cnt + 32'd1;
                end
            end

            S_ISSUE: begin
                // pc_src / imm_ext only matter on the cycle the stall lifts.
                if (!i_stall) begin
                    w_valid_nxt = 1'b0;
`ifdef MISALIGN_TRAP_EN
                    w_pc_nxt = w_target;
                    if (w_target[1:0] != 2'b00) begin
                        w_err_nxt   = 1'b1;
                        w_req_nxt   = 1'b0;
                        w_state_nxt = S_ERROR;
                    end else begin
                        w_req_nxt   = 1'b1;
                        w_state_nxt = S_FETCH;
                    end
`else
                    w_pc_nxt    = w_target & ~32'd3;
                    w_req_nxt   = 1'b1;
                    w_state_nxt = S_FETCH;
`endif
                end
            end

            S_ERROR: begin
                w_req_nxt   = 1'b0;
                w_valid_nxt = 1'b0;
            end

            default: begin
                w_state_nxt = S_BOOT;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= S_BOOT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Datapath / output registers
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_pc    <= RESET_PC;
            r_instr <= NOP_INSTR;
            r_valid <= 1'b0;
            r_req   <= 1'b0;
            r_err   <= 1'b0;
            r_cnt   <= 32'd0;
        end else begin
            r_pc    <= w_pc_nxt;
            r_instr <= w_instr_nxt;
            r_valid <= w_valid_nxt;
            r_req   <= w_req_nxt;
            r_err   <= w_err_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    assign imem.imem_req   = r_req;
    assign imem.imem_addr  = r_pc;
    assign o_instr         = r_instr;
    assign o_pc            = r_pc;
    assign o_pc_plus4      = r_pc + 32'd4;
    assign o_instr_valid   = r_valid;
    assign o_fetch_err     = r_err;

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Fetch stage directly upstream of sign_extension and the decoder.
- Holds the PC and fetches each instruction from instruction memory using a ready-based handshake with variable latency.
- Presents the instruction word to decode and sign extension.
- Consumes the resulting ImmExt to compute the branch/jump target for the next PC.
- Operates as a multi-cycle fetcher with stall support, a fetch timeout and a sticky error flag.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
IMEM_TIMEOUT, 255, maximum wait cycles in FETCH before error; 0 disables the timeout.

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  synchronous, active-low reset.
stall  input  1  downstream hold; freezes the issued instruction and the PC.
pc_src  input  1  1 = next PC is pc+imm_ext (branch/jump taken); 0 = pc+4.
imm_ext  input  32  immediate from sign_extension for the currently issued instr.
imem_req  output  1  fetch request to instruction memory (registered).
imem_addr  output  32  fetch address; always equals pc.
imem_rdata  input  32  instruction data; valid when imem_ready=1.
imem_ready  input  1  memory completes the request in this cycle.
instr  output  32  issued instruction word; feeds decoder and sign_extension.
pc  output  32  address of instr.
pc_plus4  output  32  pc+4 (combinational), for JAL/JALR link.
instr_valid  output  1  instr/pc are valid for execution.
fetch_err  output  1  sticky fault flag.

Behaviour:
- Reset is sampled at posedge while rst_n=0 and has priority over everything, including mid-WAIT.
  - pc<=RESET_PC, instr<=32'h0000_0013 (NOP), instr_valid<=0, imem_req<=0, fetch_err<=0, wait counter<=0, state<=BOOT.
- States: BOOT, FETCH, ISSUE, ERROR.
- BOOT: one cycle, then imem_req<=1 and state FETCH.
- FETCH: imem_req=1, imem_addr=pc.
  - Posedge with imem_ready=1: instr<=imem_rdata, instr_valid<=1, imem_req<=0, counter<=0, state ISSUE.
  - Otherwise counter increments. When counter reaches IMEM_TIMEOUT-1 without ready (IMEM_TIMEOUT≠0): fetch_err<=1, imem_req<=0, state ERROR.
  - With zero-wait memory, ready lands in the first FETCH cycle. An instruction takes 2 cycles minimum (FETCH+ISSUE).
- ISSUE: instr_valid=1, and instr, pc and imm_ext are stable.
  - stall=1: hold all outputs; pc_src is ignored.
  - stall=0 at posedge: pc<=(pc_src ? pc+imm_ext : pc+4), instr_valid<=0, imem_req<=1, state FETCH.
- pc_src and imm_ext are sampled only in ISSUE with stall=0.
- imem_ready outside FETCH is ignored. stall outside ISSUE is ignored.
- Arithmetic is unsigned 32-bit modulo 2^32: pc 32'hFFFF_FFFC + 4 wraps to 0. imm_ext is two's complement, so negative offsets wrap naturally.
- ERROR: imem_req=0, instr_valid=0, pc and instr hold. The only exit is reset.
- fetch_err, once set, stays 1 until reset.

Optional Feature:
MISALIGN_TRAP_EN
- Defined: if the computed next-PC has [1:0]≠2'b00, then at the ISSUE→next transition pc<=unmodified target, fetch_err<=1, state ERROR, and no request is issued.
- Undefined: target[1:0] is forced to 2'b00 before loading pc, with no error.

Test Plan:
1. Reset, zero-wait memory returning 32'h0000_0013: imem_addr reads 0,4,8 on successive fetches; instr_valid is high every 2nd cycle; fetch_err=0.
2. Memory with 3 wait cycles: imem_req stays high for 4 cycles; instr_valid rises the cycle after ready; pc stays unchanged throughout.
3. pc=32'h10 in ISSUE with pc_src=1, imm_ext=32'hFFFF_FFF8 → next imem_addr=32'h08. With pc_src=0 → 32'h14.
4. stall=1 for 5 cycles in ISSUE while imm_ext and pc_src toggle: instr and pc are unchanged and no request is issued. On release with pc_src=0, pc advances by 4.
5. IMEM_TIMEOUT=4, imem_ready held 0 → after 4 FETCH cycles fetch_err=1 and imem_req=0. Raising ready later has no effect until rst_n=0, which reloads pc to RESET_PC.
6. pc=0, pc_src=1, imm_ext=32'h6. With MISALIGN_TRAP_EN: fetch_err=1 and pc=6. Without it: next imem_addr=32'h4. Also assert rst_n=0 mid-FETCH → BOOT state, instr=NOP.
